// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one memory buffer reader command port among
// NUM_REQ requesters. The reader's output stream is routed back to the owning
// requester through a small FIFO of grant indices, one packet per acked command.
module mem_rd_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int REQ_IDX_WIDTH       = 2,
  parameter int ROUTE_FIFO_DEPTH    = 4,
  parameter int MEM_BUF_IDX_WIDTH   = 4,
  parameter int MEM_BEAT_ADDR_WIDTH = 16,
  parameter int AXI4S_DATA_WIDTH    = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_REQ*MEM_BUF_IDX_WIDTH-1:0]     req_buf_idx_in,
  input  logic [NUM_REQ*MEM_BEAT_ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQ*MEM_BEAT_ADDR_WIDTH-1:0]   req_width_in,
  input  logic [NUM_REQ*MEM_BEAT_ADDR_WIDTH-1:0]   req_offset_in,
  input  logic [NUM_REQ*MEM_BEAT_ADDR_WIDTH-1:0]   req_count_in,
  input  logic [NUM_REQ*AXI4S_DATA_WIDTH-1:0]      req_header_in,
  input  logic [NUM_REQ-1:0]                       req_header_valid_in,
  input  logic [NUM_REQ-1:0]                       req_header_only_in,
  input  logic [NUM_REQ-1:0]                       req_valid_in,
  output logic [NUM_REQ-1:0]                       req_ack_out,
  output logic [AXI4S_DATA_WIDTH-1:0]              req_axis_tdata,
  output logic                                     req_axis_tlast,
  output logic [NUM_REQ-1:0]                       req_axis_tvalid,
  input  logic [NUM_REQ-1:0]                       req_axis_tready,
  output logic [MEM_BUF_IDX_WIDTH-1:0]             rd_buf_idx_out,
  output logic [MEM_BEAT_ADDR_WIDTH-1:0]           rd_addr_out,
  output logic [MEM_BEAT_ADDR_WIDTH-1:0]           rd_width_out,
  output logic [MEM_BEAT_ADDR_WIDTH-1:0]           rd_offset_out,
  output logic [MEM_BEAT_ADDR_WIDTH-1:0]           rd_count_out,
  output logic [AXI4S_DATA_WIDTH-1:0]              rd_header_out,
  output logic                                     rd_header_valid_out,
  output logic                                     rd_header_only_out,
  output logic                                     rd_valid_out,
  input  logic                                     rd_ack_in,
  input  logic [AXI4S_DATA_WIDTH-1:0]              rd_axis_tdata,
  input  logic                                     rd_axis_tlast,
  input  logic                                     rd_axis_tvalid,
  output logic                                     rd_axis_tready,
  output logic [REQ_IDX_WIDTH-1:0]                 grant_idx_out,
  output logic [REQ_IDX_WIDTH:0]                   fifo_level_out,
  output logic                                     route_err_out
);

  localparam int BW     = MEM_BUF_IDX_WIDTH;
  localparam int AW     = MEM_BEAT_ADDR_WIDTH;
  localparam int DW     = AXI4S_DATA_WIDTH;
  localparam int PTR_W  = REQ_IDX_WIDTH + 1;
  localparam int ADDR_W = (ROUTE_FIFO_DEPTH > 1) ? $clog2(ROUTE_FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RELEASE} state_t;

  state_t                   r_state, w_state_next;
  logic [REQ_IDX_WIDTH-1:0] r_last_grant, r_grant;
  logic [NUM_REQ-1:0]       r_ack;
  logic                     r_rd_valid;
  logic [BW-1:0]            r_buf_idx;
  logic [AW-1:0]            r_addr, r_width, r_offset, r_count;
  logic [DW-1:0]            r_header;
  logic                     r_header_valid, r_header_only;
  logic                     r_route_err;

  logic [REQ_IDX_WIDTH-1:0] r_fifo [ROUTE_FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr, r_rd_ptr, r_level;

  logic [BW-1:0]            w_buf_idx [NUM_REQ];
  logic [AW-1:0]            w_addr    [NUM_REQ];
  logic [AW-1:0]            w_width   [NUM_REQ];
  logic [AW-1:0]            w_offset  [NUM_REQ];
  logic [AW-1:0]            w_count   [NUM_REQ];
  logic [DW-1:0]            w_header  [NUM_REQ];

  logic [REQ_IDX_WIDTH-1:0] w_sel, w_cand, w_head;
  logic                     w_any, w_full, w_nonempty;
  logic                     w_load, w_push, w_pop;

  // Split the flat per-requester buses into indexable arrays.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_buf_idx[gi] = req_buf_idx_in[gi*BW +: BW];
    assign w_addr[gi]    = req_addr_in[gi*AW +: AW];
    assign w_width[gi]   = req_width_in[gi*AW +: AW];
    assign w_offset[gi]  = req_offset_in[gi*AW +: AW];
    assign w_count[gi]   = req_count_in[gi*AW +: AW];
    assign w_header[gi]  = req_header_in[gi*DW +: DW];
  end

  assign w_full     = (r_level == PTR_W'(ROUTE_FIFO_DEPTH));
  assign w_nonempty = (r_level != '0);
  assign w_head     = r_fifo[r_rd_ptr[ADDR_W-1:0]];

  // Round-robin pick: scan downward so the closest requester above last grant wins.
  always_comb begin
    w_sel  = '0;
    w_any  = 1'b0;
    w_cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = REQ_IDX_WIDTH'((int'(r_last_grant) + k) % NUM_REQ);
      if (req_valid_in[w_cand]) begin
        w_sel = w_cand;
        w_any = 1'b1;
      end
    end
  end

  // Next-state logic; grants are held off while every route slot is taken.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && !w_full) begin
          w_load       = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rd_ack_in) begin
          w_push       = 1'b1;
          w_state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // State, captured command fields and the one-cycle requester ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      r_grant        <= '0;
      r_ack          <= '0;
      r_rd_valid     <= 1'b0;
      r_buf_idx      <= '0;
      r_addr         <= '0;
      r_width        <= '0;
      r_offset       <= '0;
      r_count        <= '0;
      r_header       <= '0;
      r_header_valid <= 1'b0;
      r_header_only  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= '0;
      if (w_load) begin
        r_grant        <= w_sel;
        r_rd_valid     <= 1'b1;
        r_buf_idx      <= w_buf_idx[w_sel];
        r_addr         <= w_addr[w_sel];
        r_width        <= w_width[w_sel];
        r_offset       <= w_offset[w_sel];
        r_count        <= w_count[w_sel];
        r_header       <= w_header[w_sel];
        r_header_valid <= req_header_valid_in[w_sel];
        r_header_only  <= req_header_only_in[w_sel];
      end
      if (w_push) begin
        r_rd_valid   <= 1'b0;
        r_ack        <= NUM_REQ'(1) << r_grant;
        r_last_grant <= r_grant;
      end
    end
  end

  // Route FIFO storage; entry written behind any entry popped in the same cycle.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr[ADDR_W-1:0]] <= r_grant;
  end

  // Route FIFO pointers, occupancy and the sticky stray-beat error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_route_err <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(ROUTE_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(ROUTE_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (rd_axis_tvalid && !w_nonempty) r_route_err <= 1'b1;
    end
  end

  // Stream demux: only the FIFO head sees valid, and only its ready reaches the reader.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_demux
    assign req_axis_tvalid[gi] = w_nonempty && rd_axis_tvalid && (w_head == REQ_IDX_WIDTH'(gi));
  end

  assign rd_axis_tready = w_nonempty && req_axis_tready[w_head];
  assign w_pop          = rd_axis_tvalid && rd_axis_tready && rd_axis_tlast;
  assign req_axis_tdata = rd_axis_tdata;
  assign req_axis_tlast = rd_axis_tlast;

  assign req_ack_out         = r_ack;
  assign rd_buf_idx_out      = r_buf_idx;
  assign rd_addr_out         = r_addr;
  assign rd_width_out        = r_width;
  assign rd_offset_out       = r_offset;
  assign rd_count_out        = r_count;
  assign rd_header_out       = r_header;
  assign rd_header_valid_out = r_header_valid;
  assign rd_header_only_out  = r_header_only;
  assign rd_valid_out        = r_rd_valid;
  assign grant_idx_out       = r_grant;
  assign fifo_level_out      = r_level;
  assign route_err_out       = r_route_err;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Scoreboard bench for mem_rd_arbiter: grant order comes from a round-robin
// model, acked grants are queued and popped as packets are streamed back.
module tb_mem_rd_arbiter;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int BW = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NR*BW-1:0] req_buf_idx_in;
  logic [NR*AW-1:0] req_addr_in, req_width_in, req_offset_in, req_count_in;
  logic [NR*DW-1:0] req_header_in;
  logic [NR-1:0]    req_header_valid_in, req_header_only_in, req_valid_in;
  logic [NR-1:0]    req_ack_out;
  logic [DW-1:0]    req_axis_tdata;
  logic             req_axis_tlast;
  logic [NR-1:0]    req_axis_tvalid;
  logic [NR-1:0]    req_axis_tready;
  logic [BW-1:0]    rd_buf_idx_out;
  logic [AW-1:0]    rd_addr_out, rd_width_out, rd_offset_out, rd_count_out;
  logic [DW-1:0]    rd_header_out;
  logic             rd_header_valid_out, rd_header_only_out, rd_valid_out;
  logic             rd_ack_in;
  logic [DW-1:0]    rd_axis_tdata;
  logic             rd_axis_tlast, rd_axis_tvalid, rd_axis_tready;
  logic [IW-1:0]    grant_idx_out;
  logic [IW:0]      fifo_level_out;
  logic             route_err_out;

  logic [BW-1:0] tb_buf [NR];
  logic [AW-1:0] tb_addr [NR];
  logic [AW-1:0] tb_count [NR];
  logic [DW-1:0] tb_header [NR];
  logic [NR-1:0] tb_valid;

  int pass_cnt = 0;
  int total_cnt = 0;
  int route_q[$];
  int model_last = NR - 1;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign req_buf_idx_in[gi*BW +: BW] = tb_buf[gi];
    assign req_addr_in[gi*AW +: AW]    = tb_addr[gi];
    assign req_width_in[gi*AW +: AW]   = AW'(gi + 8);
    assign req_offset_in[gi*AW +: AW]  = AW'(gi * 2);
    assign req_count_in[gi*AW +: AW]   = tb_count[gi];
    assign req_header_in[gi*DW +: DW]  = tb_header[gi];
  end
  assign req_header_valid_in = 4'b0101;
  assign req_header_only_in  = 4'b0000;
  assign req_valid_in        = tb_valid;

  mem_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .req_buf_idx_in(req_buf_idx_in), .req_addr_in(req_addr_in),
    .req_width_in(req_width_in), .req_offset_in(req_offset_in),
    .req_count_in(req_count_in), .req_header_in(req_header_in),
    .req_header_valid_in(req_header_valid_in), .req_header_only_in(req_header_only_in),
    .req_valid_in(req_valid_in), .req_ack_out(req_ack_out),
    .req_axis_tdata(req_axis_tdata), .req_axis_tlast(req_axis_tlast),
    .req_axis_tvalid(req_axis_tvalid), .req_axis_tready(req_axis_tready),
    .rd_buf_idx_out(rd_buf_idx_out), .rd_addr_out(rd_addr_out),
    .rd_width_out(rd_width_out), .rd_offset_out(rd_offset_out),
    .rd_count_out(rd_count_out), .rd_header_out(rd_header_out),
    .rd_header_valid_out(rd_header_valid_out), .rd_header_only_out(rd_header_only_out),
    .rd_valid_out(rd_valid_out), .rd_ack_in(rd_ack_in),
    .rd_axis_tdata(rd_axis_tdata), .rd_axis_tlast(rd_axis_tlast),
    .rd_axis_tvalid(rd_axis_tvalid), .rd_axis_tready(rd_axis_tready),
    .grant_idx_out(grant_idx_out), .fifo_level_out(fifo_level_out),
    .route_err_out(route_err_out)
  );

  // Round-robin reference: first valid requester above the last grant, with wrap.
  function automatic int rr_next(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tb_valid = '0;
    rd_ack_in = 1'b0;
    rd_axis_tvalid = 1'b0;
    rd_axis_tlast = 1'b0;
    rd_axis_tdata = '0;
    req_axis_tready = '1;
    for (int i = 0; i < NR; i++) begin
      tb_buf[i] = BW'(i + 1);
      tb_addr[i] = AW'(16'h0200 + i * 16'h0010);
      tb_count[i] = AW'(i + 1);
      tb_header[i] = 32'hA000_0000 + i;
    end
    route_q.delete();
    model_last = NR - 1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rd_valid_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_ack(input int g);
    rd_ack_in = 1'b1;
    tick();
    rd_ack_in = 1'b0;
    route_q.push_back(g);
  endtask

  task automatic drive_packet(input int nbeats, output logic [NR-1:0] tv_seen,
                              output bit ok, output bit data_ok);
    int c;
    tv_seen = '0;
    ok = 1'b1;
    data_ok = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      rd_axis_tvalid = 1'b1;
      rd_axis_tdata = $urandom;
      rd_axis_tlast = (b == nbeats - 1);
      #1;
      c = 0;
      while (rd_axis_tready !== 1'b1 && c < 20) begin
        tick();
        #1;
        c++;
      end
      if (c >= 20) ok = 1'b0;
      tv_seen |= req_axis_tvalid;
      if (req_axis_tdata !== rd_axis_tdata || req_axis_tlast !== rd_axis_tlast) data_ok = 1'b0;
      tick();
    end
    rd_axis_tvalid = 1'b0;
    rd_axis_tlast = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    total_cnt++; if (rd_valid_out !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid_out); else pass_cnt++;
    total_cnt++; if (req_ack_out !== 4'b0) $display("FAIL reset_ack: got %b want 0000", req_ack_out); else pass_cnt++;
    total_cnt++; if (rd_addr_out !== 16'h0) $display("FAIL reset_addr: got %h want 0000", rd_addr_out); else pass_cnt++;
    total_cnt++; if (grant_idx_out !== 2'd0) $display("FAIL reset_grant: got %0d want 0", grant_idx_out); else pass_cnt++;
    total_cnt++; if (fifo_level_out !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level_out); else pass_cnt++;
    total_cnt++; if (route_err_out !== 1'b0) $display("FAIL reset_err: got %b want 0", route_err_out); else pass_cnt++;
    do_reset();
    $display("reset: rd_valid=%b level=%0d err=%b", rd_valid_out, fifo_level_out, route_err_out);
  endtask

  task automatic test_single();
    bit ok, dok;
    logic [NR-1:0] tv;
    int e;
    tb_addr[2] = 16'h0100;
    tb_count[2] = 16'd3;
    tb_valid = 4'b0100;
    wait_valid(ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL single_timeout: got no rd_valid want grant"); else pass_cnt++;
    total_cnt++; if (grant_idx_out !== 2'd2) $display("FAIL single_grant: got %0d want 2", grant_idx_out); else pass_cnt++;
    total_cnt++; if (rd_count_out !== 16'd3) $display("FAIL single_count: got %0d want 3", rd_count_out); else pass_cnt++;
    total_cnt++; if (rd_buf_idx_out !== 4'd3) $display("FAIL single_buf: got %0d want 3", rd_buf_idx_out); else pass_cnt++;
    tb_addr[2] = 16'h0555;
    repeat (3) tick();
    total_cnt++; if (rd_addr_out !== 16'h0100) $display("FAIL single_frozen_addr: got %h want 0100", rd_addr_out); else pass_cnt++;
    total_cnt++; if (rd_valid_out !== 1'b1) $display("FAIL single_hold_valid: got %b want 1", rd_valid_out); else pass_cnt++;
    do_ack(2);
    total_cnt++; if (req_ack_out !== 4'b0100) $display("FAIL single_ack: got %b want 0100", req_ack_out); else pass_cnt++;
    total_cnt++; if (rd_valid_out !== 1'b0) $display("FAIL single_valid_drop: got %b want 0", rd_valid_out); else pass_cnt++;
    tb_valid = '0;
    tick();
    total_cnt++; if (req_ack_out !== 4'b0000) $display("FAIL single_ack_clear: got %b want 0000", req_ack_out); else pass_cnt++;
    total_cnt++; if (fifo_level_out !== 3'd1) $display("FAIL single_level: got %0d want 1", fifo_level_out); else pass_cnt++;
    drive_packet(3, tv, ok, dok);
    e = route_q.pop_front();
    total_cnt++; if (tv !== 4'(1 << e) || !ok) $display("FAIL single_route: got %b want %b", tv, 4'(1 << e)); else pass_cnt++;
    total_cnt++; if (dok !== 1'b1) $display("FAIL single_data: got mismatching tdata/tlast want passthrough"); else pass_cnt++;
    total_cnt++; if (fifo_level_out !== 3'd0) $display("FAIL single_pop_level: got %0d want 0", fifo_level_out); else pass_cnt++;
    $display("single: grant=2 addr=0100 routed=%b", tv);
  endtask

  task automatic test_round_robin();
    bit ok, dok;
    logic [NR-1:0] tv;
    int e, p;
    do_reset();
    tb_valid = 4'b1011;
    for (int n = 0; n < 6; n++) begin
      e = rr_next(model_last, tb_valid);
      wait_valid(ok);
      total_cnt++; if (ok !== 1'b1) $display("FAIL rr_timeout: got no grant want %0d", e); else pass_cnt++;
      total_cnt++; if (int'(grant_idx_out) != e) $display("FAIL rr_grant: got %0d want %0d", grant_idx_out, e); else pass_cnt++;
      total_cnt++; if (rd_addr_out !== tb_addr[e]) $display("FAIL rr_addr: got %h want %h", rd_addr_out, tb_addr[e]); else pass_cnt++;
      do_ack(e);
      model_last = e;
      total_cnt++; if (req_ack_out !== 4'(1 << e)) $display("FAIL rr_ack: got %b want %b", req_ack_out, 4'(1 << e)); else pass_cnt++;
      drive_packet(1, tv, ok, dok);
      p = route_q.pop_front();
      total_cnt++; if (tv !== 4'(1 << p) || !ok) $display("FAIL rr_route: got %b want %b", tv, 4'(1 << p)); else pass_cnt++;
      $display("round_robin: grant %0d = %0d", n, grant_idx_out);
    end
    tb_valid = '0;
  endtask

  task automatic test_fifo_full();
    bit ok, dok;
    logic [NR-1:0] tv;
    int e, p;
    do_reset();
    tb_valid = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      e = rr_next(model_last, tb_valid);
      wait_valid(ok);
      total_cnt++; if (ok !== 1'b1 || int'(grant_idx_out) != e) $display("FAIL full_grant: got %0d want %0d", grant_idx_out, e); else pass_cnt++;
      do_ack(e);
      model_last = e;
    end
    tick();
    total_cnt++; if (fifo_level_out !== 3'd4) $display("FAIL full_level: got %0d want 4", fifo_level_out); else pass_cnt++;
    repeat (5) tick();
    total_cnt++; if (rd_valid_out !== 1'b0) $display("FAIL full_blocked: got rd_valid %b want 0", rd_valid_out); else pass_cnt++;
    e = rr_next(model_last, tb_valid);
    drive_packet(1, tv, ok, dok);
    p = route_q.pop_front();
    total_cnt++; if (tv !== 4'(1 << p) || !ok) $display("FAIL full_route: got %b want %b", tv, 4'(1 << p)); else pass_cnt++;
    ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (rd_valid_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    total_cnt++; if (ok !== 1'b1) $display("FAIL full_resume: got no grant within 2 cycles want grant"); else pass_cnt++;
    total_cnt++; if (int'(grant_idx_out) != e) $display("FAIL full_fifth: got %0d want %0d", grant_idx_out, e); else pass_cnt++;
    tb_valid = '0;
    do_ack(e);
    tick();
    for (int n = 0; n < 4; n++) begin
      drive_packet(1, tv, ok, dok);
      p = route_q.pop_front();
      total_cnt++; if (tv !== 4'(1 << p) || !ok) $display("FAIL full_drain: got %b want %b", tv, 4'(1 << p)); else pass_cnt++;
    end
    $display("fifo_full: fifth grant=%0d level=%0d", e, fifo_level_out);
  endtask

  task automatic test_backpressure();
    bit ok;
    int p;
    do_reset();
    tb_valid = 4'b0010;
    wait_valid(ok);
    tb_valid = '0;
    do_ack(1);
    tick();
    req_axis_tready = 4'b1101;
    rd_axis_tvalid = 1'b1;
    rd_axis_tlast = 1'b1;
    rd_axis_tdata = 32'hDEAD_BEEF;
    #1;
    p = route_q.pop_front();
    total_cnt++; if (rd_axis_tready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", rd_axis_tready); else pass_cnt++;
    total_cnt++; if (req_axis_tvalid !== 4'(1 << p)) $display("FAIL bp_tvalid: got %b want %b", req_axis_tvalid, 4'(1 << p)); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (fifo_level_out !== 3'd1) $display("FAIL bp_hold_level: got %0d want 1", fifo_level_out); else pass_cnt++;
    req_axis_tready = 4'b1111;
    #1;
    total_cnt++; if (rd_axis_tready !== 1'b1) $display("FAIL bp_ready_high: got %b want 1", rd_axis_tready); else pass_cnt++;
    tick();
    rd_axis_tvalid = 1'b0;
    rd_axis_tlast = 1'b0;
    total_cnt++; if (fifo_level_out !== 3'd0) $display("FAIL bp_pop: got %0d want 0", fifo_level_out); else pass_cnt++;
    $display("backpressure: head=%0d level=%0d", p, fifo_level_out);
  endtask

  task automatic test_simultaneous();
    bit ok, dok;
    logic [NR-1:0] tv;
    int p;
    do_reset();
    for (int g = 0; g < 2; g++) begin
      tb_valid = 4'(1 << g);
      wait_valid(ok);
      tb_valid = '0;
      total_cnt++; if (ok !== 1'b1 || int'(grant_idx_out) != g) $display("FAIL sim_setup: got %0d want %0d", grant_idx_out, g); else pass_cnt++;
      do_ack(g);
    end
    tick();
    total_cnt++; if (fifo_level_out !== 3'd2) $display("FAIL sim_level_pre: got %0d want 2", fifo_level_out); else pass_cnt++;
    tb_valid = 4'b0100;
    wait_valid(ok);
    tb_valid = '0;
    rd_ack_in = 1'b1;
    rd_axis_tvalid = 1'b1;
    rd_axis_tlast = 1'b1;
    #1;
    p = route_q.pop_front();
    total_cnt++; if (req_axis_tvalid !== 4'(1 << p)) $display("FAIL sim_route: got %b want %b", req_axis_tvalid, 4'(1 << p)); else pass_cnt++;
    tick();
    rd_ack_in = 1'b0;
    rd_axis_tvalid = 1'b0;
    rd_axis_tlast = 1'b0;
    route_q.push_back(2);
    total_cnt++; if (fifo_level_out !== 3'd2) $display("FAIL sim_level_post: got %0d want 2", fifo_level_out); else pass_cnt++;
    for (int n = 0; n < 2; n++) begin
      drive_packet(2, tv, ok, dok);
      p = route_q.pop_front();
      total_cnt++; if (tv !== 4'(1 << p) || !ok) $display("FAIL sim_order: got %b want %b", tv, 4'(1 << p)); else pass_cnt++;
    end
    rd_axis_tvalid = 1'b1;
    #1;
    total_cnt++; if (req_axis_tvalid !== 4'b0000 || rd_axis_tready !== 1'b0) $display("FAIL stray_route: got tvalid %b ready %b want 0000 0", req_axis_tvalid, rd_axis_tready); else pass_cnt++;
    tick();
    rd_axis_tvalid = 1'b0;
    total_cnt++; if (route_err_out !== 1'b1) $display("FAIL stray_err: got %b want 1", route_err_out); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (route_err_out !== 1'b1) $display("FAIL stray_sticky: got %b want 1", route_err_out); else pass_cnt++;
    $display("simultaneous: level held, err=%b", route_err_out);
  endtask

  task automatic test_async_reset();
    bit ok, dok;
    logic [NR-1:0] tv;
    int e, p;
    tb_valid = 4'b0100;
    wait_valid(ok);
    total_cnt++; if (ok !== 1'b1) $display("FAIL ar_setup: got no grant want grant"); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    total_cnt++; if (rd_valid_out !== 1'b0) $display("FAIL ar_valid: got %b want 0", rd_valid_out); else pass_cnt++;
    total_cnt++; if (route_err_out !== 1'b0 || fifo_level_out !== 3'd0) $display("FAIL ar_clear: got err %b level %0d want 0 0", route_err_out, fifo_level_out); else pass_cnt++;
    tb_valid = 4'b0101;
    route_q.delete();
    model_last = NR - 1;
    tick();
    reset = 1'b1;
    e = rr_next(model_last, tb_valid);
    wait_valid(ok);
    total_cnt++; if (ok !== 1'b1 || int'(grant_idx_out) != e) $display("FAIL ar_priority: got %0d want %0d", grant_idx_out, e); else pass_cnt++;
    tb_valid = '0;
    do_ack(e);
    tick();
    drive_packet(1, tv, ok, dok);
    p = route_q.pop_front();
    total_cnt++; if (tv !== 4'(1 << p) || !ok) $display("FAIL ar_route: got %b want %b", tv, 4'(1 << p)); else pass_cnt++;
    $display("async_reset: first grant after reset=%0d", grant_idx_out);
  endtask

  initial begin
    tb_valid = '0;
    rd_ack_in = 1'b0;
    rd_axis_tvalid = 1'b0;
    rd_axis_tlast = 1'b0;
    rd_axis_tdata = '0;
    req_axis_tready = '1;
    for (int i = 0; i < NR; i++) begin
      tb_buf[i] = '0;
      tb_addr[i] = '0;
      tb_count[i] = '0;
      tb_header[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
